// File: rtl/spi_reg_bank.sv
// SPI (mode 0) slave exposing a small bank of write/read registers.
// Frame: R/W bit (1 = write), address, data; all MSB first, sampled on sync sclk rising edges.
module spi_reg_bank #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_strobe_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic                       err_frame_o,
    output logic                       err_addr_o,
    output logic [7:0]                 frame_cnt_o,
    output logic [1:0]                 state_o
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2, ABORT = 2'd3} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0]    sclk_sync, copi_sync, ncs_sync;
    logic                      sclk_d, ncs_d;
    logic [CNT_W-1:0]          cnt;
    logic [FRAME_LEN-1:0]      sh;
    logic [DATA_W-1:0]         rd_sh;
    logic                      rd_active;
    logic [NUM_REGS*DATA_W-1:0] regs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;

    logic [FRAME_LEN-1:0] sh_next;
    logic                 frame_wr;
    logic [ADDR_W-1:0]    frame_addr;
    logic [DATA_W-1:0]    frame_data;
    logic                 addr_ok;
    assign sh_next    = {sh[FRAME_LEN-2:0], copi_s};
    assign frame_wr   = sh[FRAME_LEN-1];
    assign frame_addr = sh[FRAME_LEN-2 -: ADDR_W];
    assign frame_data = sh[DATA_W-1:0];
    assign addr_ok    = 32'(frame_addr) < NUM_REGS;

    // Unimplemented addresses read back as zero.
    function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
        reg_at = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (a == ADDR_W'(i)) reg_at = regs_q[i*DATA_W +: DATA_W];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sh          <= '0;
            rd_sh       <= '0;
            rd_active   <= 1'b0;
            regs_q      <= RST_VAL;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            err_frame_o <= 1'b0;
            err_addr_o  <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            wr_strobe_o <= 1'b0;
            err_frame_o <= 1'b0;
            err_addr_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state     <= SHIFT;
                        cnt       <= '0;
                        sh        <= '0;
                        rd_active <= 1'b0;
                    end
                end
                SHIFT: begin
                    // ncs release wins over an sclk edge seen in the same cycle.
                    if (ncs_rise) begin
                        state     <= (cnt == CNT_W'(FRAME_LEN)) ? COMMIT : ABORT;
                        rd_active <= 1'b0;
                    end else if (sclk_rise) begin
                        if (cnt < CNT_W'(FRAME_LEN)) sh <= sh_next;
                        if (cnt < CNT_W'(FRAME_LEN + 1)) cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ADDR_W) && !sh_next[ADDR_W]) begin
                            rd_active <= 1'b1;
                            rd_sh     <= reg_at(sh_next[ADDR_W-1:0]);
                        end
                    end else if (sclk_fall && rd_active && cnt > CNT_W'(ADDR_W + 1)) begin
                        // Advance only after the host has sampled the current data bit.
                        rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (frame_wr) begin
                        if (addr_ok) begin
                            for (int i = 0; i < NUM_REGS; i++)
                                if (frame_addr == ADDR_W'(i))
                                    regs_q[i*DATA_W +: DATA_W] <= frame_data;
                            wr_strobe_o <= 1'b1;
                            wr_addr_o   <= frame_addr;
                            frame_cnt_o <= frame_cnt_o + 8'd1;
                        end else begin
                            err_addr_o <= 1'b1;
                        end
                    end
                end
                ABORT: begin
                    state       <= IDLE;
                    err_frame_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cipo_oe = rd_active & ~ncs_s;
    assign cipo    = cipo_oe & rd_sh[DATA_W-1];
    assign regs_o  = regs_q;
    assign state_o = state;
endmodule
